// File: rtl/ram_req_ctrl.sv
// Valid/ready request front-end for the small register RAM: sequences writes and
// reads into correctly timed r_w/address/data and returns read data on a response channel.
module ram_req_ctrl #(
   parameter int ADDR_W    = 1,
   parameter int DATA_W    = 8,
   parameter int READ_WAIT = 0,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              mem_r_w,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

   localparam logic [1:0] WAIT_INIT = 2'(READ_WAIT);

   state_t     state_r;
   logic [1:0] wait_r;

   // Only IDLE accepts, so ready is a pure decode of the state register.
   assign req_ready = (state_r == ST_IDLE);

   // Request sequencer: owns the state, the RAM controls, the response and the counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         wait_r    <= 2'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_addr  <= '0;
         mem_r_w   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  mem_addr <= req_addr;
                  if (req_we) begin
                     mem_wdata <= req_wdata;
                     mem_r_w   <= 1'b1;
                     state_r   <= ST_WR;
                  end else begin
                     mem_r_w <= 1'b0;
                     wait_r  <= WAIT_INIT;
                     state_r <= ST_RD;
                  end
               end else begin
                  mem_r_w <= 1'b0;
               end
            end
            // The RAM latches mem_wdata at this edge, so r_w drops right behind it.
            ST_WR: begin
               mem_r_w <= 1'b0;
               wr_cnt  <= wr_cnt + CNT_W'(1);
               state_r <= ST_IDLE;
            end
            // RAM data_out was refreshed at the negedge inside this cycle.
            ST_RD: begin
               mem_r_w <= 1'b0;
               if (wait_r == 2'd0) begin
                  rsp_rdata <= mem_rdata;
                  rsp_addr  <= mem_addr;
                  rsp_valid <= 1'b1;
                  state_r   <= ST_RSP;
               end else begin
                  wait_r <= wait_r - 2'd1;
               end
            end
            ST_RSP: begin
               mem_r_w <= 1'b0;
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rd_cnt    <= rd_cnt + CNT_W'(1);
                  state_r   <= ST_IDLE;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               mem_r_w   <= 1'b0;
               rsp_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl: two instances (READ_WAIT=0 and 2), each with a
// behavioural RAM, checked against a reference memory/counter model kept in the bench.
module tb_ram_req_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_we = 1'b0;
   logic [0:0] req_addr = 1'b0;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_ready = 1'b0;
   int         sel = 0;

   logic       a_req_ready, a_rsp_valid, a_mem_r_w;
   logic [7:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata, a_wr_cnt, a_rd_cnt;
   logic [0:0] a_rsp_addr, a_mem_addr;
   logic       b_req_ready, b_rsp_valid, b_mem_r_w;
   logic [7:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata, b_wr_cnt, b_rd_cnt;
   logic [0:0] b_rsp_addr, b_mem_addr;

   logic [7:0] a_ram [2];
   logic [7:0] b_ram [2];

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] exp_mem [2][2];
   int         exp_wr [2];
   int         exp_rd [2];

   always #5 clk = ~clk;

   ram_req_ctrl #(.ADDR_W(1), .DATA_W(8), .READ_WAIT(0), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && (sel == 0)), .req_ready(a_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && (sel == 0)),
      .rsp_rdata(a_rsp_rdata), .rsp_addr(a_rsp_addr),
      .mem_r_w(a_mem_r_w), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .wr_cnt(a_wr_cnt), .rd_cnt(a_rd_cnt)
   );

   ram_req_ctrl #(.ADDR_W(1), .DATA_W(8), .READ_WAIT(2), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid && (sel == 1)), .req_ready(b_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && (sel == 1)),
      .rsp_rdata(b_rsp_rdata), .rsp_addr(b_rsp_addr),
      .mem_r_w(b_mem_r_w), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .wr_cnt(b_wr_cnt), .rd_cnt(b_rd_cnt)
   );

   // Behavioural register RAM: write on posedge when r_w=1, read data on negedge when r_w=0.
   always @(posedge clk) if (a_mem_r_w) a_ram[a_mem_addr] <= a_mem_wdata;
   always @(negedge clk) if (!a_mem_r_w) a_mem_rdata <= a_ram[a_mem_addr];
   always @(posedge clk) if (b_mem_r_w) b_ram[b_mem_addr] <= b_mem_wdata;
   always @(negedge clk) if (!b_mem_r_w) b_mem_rdata <= b_ram[b_mem_addr];

   wire       ready_m = (sel == 0) ? a_req_ready : b_req_ready;
   wire       rv_m    = (sel == 0) ? a_rsp_valid : b_rsp_valid;
   wire [7:0] rd_m    = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
   wire [0:0] ra_m    = (sel == 0) ? a_rsp_addr  : b_rsp_addr;
   wire       rw_m    = (sel == 0) ? a_mem_r_w   : b_mem_r_w;
   wire [0:0] ma_m    = (sel == 0) ? a_mem_addr  : b_mem_addr;
   wire [7:0] mw_m    = (sel == 0) ? a_mem_wdata : b_mem_wdata;
   wire [7:0] wc_m    = (sel == 0) ? a_wr_cnt    : b_wr_cnt;
   wire [7:0] rc_m    = (sel == 0) ? a_rd_cnt    : b_rd_cnt;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle();
      int n = 0;
      #1;
      while (!ready_m && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (!ready_m) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_idle: req_ready got 0 want 1 within 50 cycles (inst %0d)", sel);
      end
   endtask

   // After acceptance the request lines are either released or scrambled while held.
   task automatic agitate(input bit hold);
      if (hold) begin
         req_we    = 1'($urandom);
         req_addr  = 1'($urandom);
         req_wdata = 8'($urandom);
      end else begin
         req_valid = 1'b0;
      end
   endtask

   task automatic do_write(input logic [0:0] addr, input logic [7:0] data, input bit hold);
      wait_idle();
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
      @(posedge clk); #1;
      n_cmp++; if (rw_m !== 1'b1) begin n_fail++; $display("FAIL wr_rw_high: got %0d want 1", rw_m); end
      n_cmp++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL wr_ready_low: got %0d want 0", ready_m); end
      n_cmp++; if (ma_m !== addr) begin n_fail++; $display("FAIL wr_addr: got %0h want %0h", ma_m, addr); end
      n_cmp++; if (mw_m !== data) begin n_fail++; $display("FAIL wr_data: got %0h want %0h", mw_m, data); end
      @(negedge clk);
      agitate(hold);
      @(posedge clk); #1;
      exp_mem[sel][addr] = data;
      exp_wr[sel]++;
      n_cmp++; if (rw_m !== 1'b0) begin n_fail++; $display("FAIL wr_rw_drop: got %0d want 0", rw_m); end
      n_cmp++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL wr_ready_back: got %0d want 1", ready_m); end
      n_cmp++; if (wc_m !== 8'(exp_wr[sel] % 256)) begin n_fail++; $display("FAIL wr_cnt: got %0d want %0d", wc_m, exp_wr[sel] % 256); end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [0:0] addr, input int delay, input bit hold);
      int lat;
      lat = 1 + ((sel == 0) ? 0 : 2);
      wait_idle();
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = 8'($urandom);
      @(posedge clk); #1;
      n_cmp++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL rd_ready_low: got %0d want 0", ready_m); end
      for (int k = 1; k <= lat; k++) begin
         n_cmp++; if (rv_m !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid: got %0d want 0 (k=%0d)", rv_m, k); end
         n_cmp++; if (rw_m !== 1'b0) begin n_fail++; $display("FAIL rd_rw: got %0d want 0", rw_m); end
         @(negedge clk);
         agitate(hold);
         @(posedge clk); #1;
      end
      for (int d = 0; d <= delay; d++) begin
         n_cmp++; if (rv_m !== 1'b1) begin n_fail++; $display("FAIL rsp_valid: got %0d want 1 (d=%0d)", rv_m, d); end
         n_cmp++; if (rd_m !== exp_mem[sel][addr]) begin n_fail++; $display("FAIL rsp_rdata: got %0h want %0h", rd_m, exp_mem[sel][addr]); end
         n_cmp++; if (ra_m !== addr) begin n_fail++; $display("FAIL rsp_addr: got %0h want %0h", ra_m, addr); end
         n_cmp++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL rsp_ready_low: got %0d want 0", ready_m); end
         n_cmp++; if (rw_m !== 1'b0) begin n_fail++; $display("FAIL rsp_rw: got %0d want 0", rw_m); end
         @(negedge clk);
         agitate(hold);
         rsp_ready = (d == delay);
         if (d < delay) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      exp_rd[sel]++;
      n_cmp++; if (rv_m !== 1'b0) begin n_fail++; $display("FAIL hand_valid: got %0d want 0", rv_m); end
      n_cmp++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL hand_ready: got %0d want 1", ready_m); end
      n_cmp++; if (rc_m !== 8'(exp_rd[sel] % 256)) begin n_fail++; $display("FAIL rd_cnt: got %0d want %0d", rc_m, exp_rd[sel] % 256); end
      n_cmp++; if (wc_m !== 8'(exp_wr[sel] % 256)) begin n_fail++; $display("FAIL rd_wr_cnt: got %0d want %0d", wc_m, exp_wr[sel] % 256); end
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      for (int s = 0; s < 2; s++) begin
         sel = s; #1;
         n_cmp++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %0d want 1 (inst %0d)", tag, ready_m, s); end
         n_cmp++; if (rv_m !== 1'b0) begin n_fail++; $display("FAIL %s_rsp_valid: got %0d want 0 (inst %0d)", tag, rv_m, s); end
         n_cmp++; if (rw_m !== 1'b0) begin n_fail++; $display("FAIL %s_mem_r_w: got %0d want 0 (inst %0d)", tag, rw_m, s); end
         n_cmp++; if (wc_m !== 8'd0) begin n_fail++; $display("FAIL %s_wr_cnt: got %0d want 0 (inst %0d)", tag, wc_m, s); end
         n_cmp++; if (rc_m !== 8'd0) begin n_fail++; $display("FAIL %s_rd_cnt: got %0d want 0 (inst %0d)", tag, rc_m, s); end
         n_cmp++; if (rd_m !== 8'd0 || ra_m !== 1'b0) begin n_fail++; $display("FAIL %s_rsp_data: got %0h/%0h want 0/0", tag, rd_m, ra_m); end
         n_cmp++; if (ma_m !== 1'b0 || mw_m !== 8'd0) begin n_fail++; $display("FAIL %s_mem_bus: got %0h/%0h want 0/0", tag, ma_m, mw_m); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_values("post_reset");
      @(negedge clk);
   endtask

   task automatic test_write_basic();
      sel = 0;
      do_write(1'b0, 8'hAA, 1'b0);
   endtask

   task automatic test_read_basic();
      sel = 0;
      do_write(1'b1, 8'hFF, 1'b0);
      do_read(1'b0, 0, 1'b0);
      do_read(1'b1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      sel = 0;
      do_read(1'b1, 3, 1'b0);
   endtask

   task automatic test_hold();
      sel = 0;
      do_write(1'b0, 8'h5A, 1'b1);
      do_read(1'b0, 1, 1'b1);
      do_read(1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         sel = int'($urandom_range(1, 0));
         if ($urandom_range(1, 0) == 1)
            do_write(1'($urandom), 8'($urandom), bit'($urandom));
         else
            do_read(1'($urandom), int'($urandom_range(3, 0)), bit'($urandom));
      end
   endtask

   task automatic test_reset_mid_read();
      sel = 1;
      wait_idle();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0d want 0", b_rsp_valid); end
      n_cmp++; if (b_mem_r_w !== 1'b0) begin n_fail++; $display("FAIL midrst_rw: got %0d want 0", b_mem_r_w); end
      n_cmp++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %0d want 1", b_req_ready); end
      n_cmp++; if (b_wr_cnt !== 8'd0 || b_rd_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", b_wr_cnt, b_rd_cnt); end
      for (int s = 0; s < 2; s++) begin
         exp_wr[s] = 0;
         exp_rd[s] = 0;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_cmp++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d want 0 (k=%0d)", b_rsp_valid, k); end
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      sel = 0;
      for (int i = 0; i < 256; i++) do_write(1'($urandom), 8'($urandom), 1'b0);
      n_cmp++; if (a_wr_cnt !== 8'd0) begin n_fail++; $display("FAIL wr_wrap: got %0d want 0", a_wr_cnt); end
   endtask

   task automatic test_read_wait();
      sel = 1;
      do_write(1'b0, 8'hAA, 1'b0);
      do_write(1'b1, 8'hFF, 1'b0);
      do_read(1'b0, 0, 1'b0);
      do_read(1'b1, 2, 1'b0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         exp_wr[s] = 0;
         exp_rd[s] = 0;
         exp_mem[s][0] = 8'h00;
         exp_mem[s][1] = 8'h00;
      end
      test_reset();
      test_write_basic();
      test_read_basic();
      test_backpressure();
      test_hold();
      test_read_wait();
      test_random();
      test_reset_mid_read();
      test_wrap();
      test_read_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
